db_ram_rd_ctrl: RTL and testbench

Read-side controller for the deblocking 128x32 dual-port line buffer. It owns the RAM's B port and converts a start/base/length command into a burst of active-low SRAM reads. The returned words are delivered in address order on a valid/ready stream, and a 2-entry output buffer absorbs the one-cycle RAM read latency under back-pressure. It sits between the deblocking RAM and the downstream fetch/output logic, opposite the filter core that writes the RAM through port A.

---
 rtl/db_ram_rd_ctrl.sv | 112 +++++++++++
 tb/tb_db_ram_rd_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/db_ram_rd_ctrl.sv
// Read-side controller for the deblocking line buffer: turns a base/length command
// into a burst of active-low SRAM reads and streams the words out on valid/ready.
module db_ram_rd_ctrl #(
  parameter int WORD_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cen_o,
  output logic                  oen_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  val_o,
  output logic [WORD_WIDTH-1:0] data_o,
  input  logic                  rdy_i
);

  // Stream handshake: a word transfers in any cycle where val_o & rdy_i; val_o never
  // drops and data_o never changes while the consumer holds rdy_i low.

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic                  done_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic [1:0]            count;
  logic                  head;
  logic [WORD_WIDTH-1:0] buf_mem [2];
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign pop    = val_o & rdy_i;
  assign val_o  = (count != 2'd0);
  assign data_o = buf_mem[head];
  // Issue only if the word would still fit once this cycle's pop is accounted for.
  assign occ    = {1'b0, count} + {2'b00, inflight};
  assign issue  = (state == S_READ) && (remaining != '0) && (occ <= 3'd1 + {2'b00, pop});

  assign cen_o  = ~issue;
  assign oen_o  = ~inflight;
  assign wen_o  = 1'b1;
  assign addr_o = rd_addr;
  assign busy_o = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) done_nxt = 1'b1;
          else             state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (issue && remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight && count == {1'b0, pop}) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done_o    <= 1'b0;
      rd_addr   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_o   <= done_nxt;
      inflight <= issue;
      if (state == S_IDLE && start_i && len_i != '0) begin
        rd_addr   <= base_i;
        remaining <= len_i;
      end else if (issue) begin
        rd_addr   <= rd_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Two-entry FIFO; the tail slot is head when empty and the other slot when one is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head       <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      if (inflight) buf_mem[head ^ count[0]] <= data_i;
      if (pop) head <= ~head;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_db_ram_rd_ctrl.sv
// Bench for db_ram_rd_ctrl: RAM model with one-cycle latency, directed and random
// commands checked against an address/word scoreboard built from the command alone.
module tb_db_ram_rd_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [4:0]   base_i;
  logic [5:0]   len_i;
  logic         busy_o, done_o, cen_o, oen_o, wen_o, val_o, rdy_i;
  logic [4:0]   addr_o;
  logic [127:0] data_i, data_o;

  logic [127:0] ram [32];
  logic [127:0] data_q;
  int checks = 0;
  int passes = 0;

  db_ram_rd_ctrl #(.WORD_WIDTH(128), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .cen_o(cen_o), .oen_o(oen_o), .wen_o(wen_o),
    .addr_o(addr_o), .data_i(data_i), .val_o(val_o), .data_o(data_o), .rdy_i(rdy_i)
  );

  // Clock and synchronous RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cen_o) data_q <= ram[addr_o];
  end
  assign data_i = data_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 rdy=1, 1 rdy pattern 1,0,0,1, 2 rdy=0 for cycles 1..10, 3 random rdy
  task automatic run_cmd(input int base, input int len, input int mode, input bit dup_start);
    int           addr_q[$];
    logic [127:0] exp_q[$];
    int           t = 0, issued = 0, popped = 0, issued_stall = 0;
    int           first_val = -1, last_pop = 0, done_t = -1;
    int           budget = 4 * len + 30;
    bit           prev_issue = 0, prev_stall = 0, finished = 0;
    logic [127:0] prev_data = '0;
    for (int i = 0; i < len; i++) begin
      addr_q.push_back((base + i) % 32);
      exp_q.push_back(ram[(base + i) % 32]);
    end
    start_i = 1'b1;
    base_i  = 5'(base);
    len_i   = 6'(len);
    while (!finished && t < budget) begin
      if (t == 1) start_i = 1'b0;
      if (dup_start && t == 4) begin
        start_i = 1'b1;
        base_i  = 5'(base + 7);
        len_i   = 6'd3;
      end
      if (dup_start && t == 5) start_i = 1'b0;
      case (mode)
        0:       rdy_i = 1'b1;
        1:       rdy_i = (t % 4 == 0) || (t % 4 == 3);
        2:       rdy_i = (t == 0) || (t > 10);
        default: rdy_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("wen_high", wen_o, 1'b1);
      chk("oen_after_issue", oen_o, !prev_issue);
      if (prev_stall) begin
        chk("stall_val_held", val_o, 1'b1);
        chk("stall_data_held", data_o, prev_data);
      end
      prev_issue = !cen_o;
      if (!cen_o) begin
        issued++;
        if (t <= 10) issued_stall++;
        if (addr_q.size() == 0) chk("extra_read", 1'b1, 1'b0);
        else chk("rd_addr", 128'(addr_o), 128'(addr_q.pop_front()));
      end
      if (val_o && first_val < 0) first_val = t;
      if (val_o && rdy_i) begin
        popped++;
        last_pop = t;
        if (exp_q.size() == 0) chk("extra_word", 1'b1, 1'b0);
        else chk("word", data_o, exp_q.pop_front());
      end
      chk("occupancy_le_2", (issued - popped) <= 2, 1'b1);
      prev_stall = val_o && !rdy_i;
      prev_data  = data_o;
      if (done_o) begin
        finished = 1;
        done_t   = t;
        chk("done_busy_low", busy_o, 1'b0);
        chk("done_all_popped", 128'(popped), 128'(len));
        if (len == 0) chk("done_len0_cycle", 128'(t), 128'd1);
        else          chk("done_after_last_pop", 128'(t), 128'(last_pop + 1));
      end else if (t == 0 || len == 0) begin
        chk("busy_low", busy_o, 1'b0);
      end else begin
        chk("busy_high", busy_o, 1'b1);
      end
      @(posedge clk);
      #1;
      t++;
    end
    rdy_i = 1'b1;
    if (!finished) chk("done_timeout", 1'b0, 1'b1);
    chk("all_reads_issued", 128'(addr_q.size()), 128'd0);
    chk("all_words_seen", 128'(exp_q.size()), 128'd0);
    if (mode == 0 && len > 0) begin
      chk("first_val_latency", 128'(first_val), 128'd3);
      chk("done_cycle", 128'(done_t), 128'(len + 3));
    end
    if (mode == 2) chk("reads_before_stall", 128'(issued_stall), 128'd2);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ram[k] = {4{32'(k)}};
    data_q  = '0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    base_i  = '0;
    len_i   = '0;
    rdy_i   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_cen", cen_o, 1'b1);
    chk("rst_oen", oen_o, 1'b1);
    chk("rst_wen", wen_o, 1'b1);
    chk("rst_addr", 128'(addr_o), 128'd0);
    chk("rst_val", val_o, 1'b0);
    chk("rst_data", data_o, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmd(0, 32, 0, 0);
    run_cmd(30, 4, 0, 0);
    run_cmd(5, 8, 1, 0);
    run_cmd(5, 8, 2, 0);
    run_cmd(9, 0, 0, 0);
    run_cmd(2, 10, 0, 1);

    // Reset in cycle 5 of a 16-word burst
    start_i = 1'b1;
    base_i  = 5'd0;
    len_i   = 6'd16;
    rdy_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cen", cen_o, 1'b1);
    chk("midrst_val", val_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_oen", oen_o, 1'b1);
    @(negedge clk);
    chk("midrst_no_done", done_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", busy_o, 1'b0);
    run_cmd(3, 6, 0, 0);

    for (int r = 0; r < 6; r++)
      run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 3, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
